// File: rtl/div_seq_pkg.sv
// Shared types for the EX-stage sequential divider.
// State encoding and default widths.
package div_seq_pkg;

  localparam int DIV_DATA_WD = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring-division iteration.
// Shifts {rem,quo} left, subtracts divisor when it fits.
module div_seq_step
  import div_seq_pkg::*;
#(
  parameter int DATA_WD = DIV_DATA_WD
) (
  input  logic [2*DATA_WD-1:0] work_i,
  input  logic [DATA_WD-1:0]   dvsr_i,
  output logic [2*DATA_WD-1:0] work_o
);

  logic [DATA_WD:0]   rem_sh;
  logic [DATA_WD:0]   diff;
  logic               ge;
  logic [DATA_WD-1:0] rem_n;
  logic [DATA_WD-1:0] quo_n;

  // rem < dvsr holds, so rem_sh < 2*dvsr and the
  // borrow shows up in the top bit of diff.
  always_comb begin
    rem_sh = work_i[2*DATA_WD-1:DATA_WD-1];
    diff   = rem_sh - {1'b0, dvsr_i};
    ge     = ~diff[DATA_WD];
    rem_n  = ge ? diff[DATA_WD-1:0]
                : rem_sh[DATA_WD-1:0];
    quo_n  = {work_i[DATA_WD-2:0], ge};
    work_o = {rem_n, quo_n};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage.
// Drives the EX stall request and the HI/LO result.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int                 DATA_WD = DIV_DATA_WD,
  parameter logic [DATA_WD-1:0] ZERO_Q  = {DATA_WD{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [DATA_WD-1:0] dividend,
  input  logic [DATA_WD-1:0] divisor,
  input  logic               annul,
  output logic               stallreq_for_div,
  output logic               result_valid,
  output logic [DATA_WD-1:0] quotient,
  output logic [DATA_WD-1:0] remainder
);

  localparam int CNT_WD = $clog2(DATA_WD);
  localparam logic [CNT_WD-1:0] CNT_LAST =
    CNT_WD'(DATA_WD - 1);

  div_state_e           state_q, state_d;
  logic [CNT_WD-1:0]    cnt_q, cnt_d;
  logic [2*DATA_WD-1:0] work_q, work_d;
  logic [DATA_WD-1:0]   dvsr_q, dvsr_d;
  logic [DATA_WD-1:0]   dvd_q, dvd_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [DATA_WD-1:0]   quo_q, quo_d;
  logic [DATA_WD-1:0]   rem_q, rem_d;

  logic                 go;
  logic                 sa;
  logic                 sb;
  logic [2*DATA_WD-1:0] step_nxt;
  logic [DATA_WD-1:0]   step_quo;
  logic [DATA_WD-1:0]   step_rem;

  div_seq_step #(
    .DATA_WD(DATA_WD)
  ) u_step (
    .work_i(work_q),
    .dvsr_i(dvsr_q),
    .work_o(step_nxt)
  );

  assign step_rem = step_nxt[2*DATA_WD-1:DATA_WD];
  assign step_quo = step_nxt[DATA_WD-1:0];

  // A dropped start or an annul both abandon the divide.
  assign go = div_start & ~annul;

  assign stallreq_for_div =
    div_start & (state_q != DIV_END) & ~annul;
  assign result_valid = (state_q == DIV_END) & ~annul;
  assign quotient     = quo_q;
  assign remainder    = rem_q;

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sa      = div_signed & dividend[DATA_WD-1];
    sb      = div_signed & divisor[DATA_WD-1];
    unique case (state_q)
      DIV_IDLE: begin
        if (go) begin
          dvd_d  = dividend;
          negq_d = sa ^ sb;
          negr_d = sa;
          dvsr_d = sb ? -divisor : divisor;
          work_d = {{DATA_WD{1'b0}},
                    sa ? -dividend : dividend};
          cnt_d  = '0;
          state_d = (divisor == '0) ? DIV_ZERO
                                    : DIV_ON;
        end
      end
      DIV_ZERO: begin
        if (go) begin
          quo_d   = ZERO_Q;
          rem_d   = dvd_q;
          state_d = DIV_END;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_ON: begin
        if (go) begin
          work_d = step_nxt;
          cnt_d  = cnt_q + CNT_WD'(1);
          if (cnt_q == CNT_LAST) begin
            quo_d   = negq_q ? -step_quo : step_quo;
            rem_d   = negr_q ? -step_rem : step_rem;
            state_d = DIV_END;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed checks for the sequential divider.
// Latency, stall length, signed cases, annul, reset.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        stallreq_for_div;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_vec;
  int n_bad;

  div_seq dut (
    .clk(clk),
    .rst(rst),
    .div_start(div_start),
    .div_signed(div_signed),
    .dividend(dividend),
    .divisor(divisor),
    .annul(annul),
    .stallreq_for_div(stallreq_for_div),
    .result_valid(result_valid),
    .quotient(quotient),
    .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a divide in the current cycle, run to the
  // result, check it, then drop div_start.
  task automatic run_div(input string tag,
                         input logic s,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eq,
                         input logic [31:0] er,
                         input int lat,
                         input int nst);
    int got_lat;
    int n_st;
    logic [31:0] q_seen;
    logic [31:0] r_seen;
    got_lat = -1;
    n_st = 0;
    q_seen = 'x;
    r_seen = 'x;
    div_start = 1'b1;
    div_signed = s;
    dividend = a;
    divisor = b;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (stallreq_for_div) n_st++;
      if (result_valid) begin
        got_lat = c;
        q_seen = quotient;
        r_seen = remainder;
        break;
      end
      next_cyc();
      #1;
    end
    chk({tag, " latency"}, got_lat, lat);
    chk({tag, " stall"}, n_st, nst);
    chk({tag, " quo"}, q_seen, eq);
    chk({tag, " rem"}, r_seen, er);
    next_cyc();
    div_start = 1'b0;
    #1;
    chk({tag, " valid drop"}, 32'(result_valid), 32'd0);
    chk({tag, " quo hold"}, quotient, eq);
  endtask

  initial begin
    int nv;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    div_start = 1'b0;
    div_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    annul = 1'b0;
    repeat (2) next_cyc();
    chk("reset quo", quotient, 32'd0);
    chk("reset rem", remainder, 32'd0);
    chk("reset valid", 32'(result_valid), 32'd0);
    chk("reset stall", 32'(stallreq_for_div), 32'd0);
    rst = 1'b0;
    next_cyc();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7,
            32'd14, 32'd2, 33, 33);
    next_cyc();
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 33);
    next_cyc();
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 32'd1, 33, 33);
    next_cyc();
    run_div("divu 0x1234/0", 1'b0, 32'h1234, 32'd0,
            32'hFFFF_FFFF, 32'h1234, 2, 2);
    next_cyc();
    run_div("divu 9/3 pre", 1'b0, 32'd9, 32'd3,
            32'd3, 32'd0, 33, 33);
    next_cyc();

    // Annul DIVU 50/5 in cycle 10.
    div_start = 1'b1;
    div_signed = 1'b0;
    dividend = 32'd50;
    divisor = 32'd5;
    repeat (10) next_cyc();
    annul = 1'b1;
    #1;
    chk("annul stall", 32'(stallreq_for_div), 32'd0);
    chk("annul valid", 32'(result_valid), 32'd0);
    next_cyc();
    annul = 1'b0;
    div_start = 1'b0;
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (result_valid) nv++;
      next_cyc();
    end
    chk("annul no result", nv, 0);
    chk("annul quo kept", quotient, 32'd3);
    run_div("divu 9/3 post", 1'b0, 32'd9, 32'd3,
            32'd3, 32'd0, 33, 33);

    // Back-to-back: new start in the cycle after END.
    div_start = 1'b1;
    div_signed = 1'b0;
    dividend = 32'd100;
    divisor = 32'd7;
    #1;
    for (int c = 0; c < 33; c++) next_cyc();
    chk("b2b first valid", 32'(result_valid), 32'd1);
    next_cyc();
    run_div("b2b divu 1000/10", 1'b0, 32'd1000,
            32'd10, 32'd100, 32'd0, 33, 33);

    // Asynchronous reset mid-ON.
    div_start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    repeat (5) next_cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst quo", quotient, 32'd0);
    chk("arst rem", remainder, 32'd0);
    chk("arst valid", 32'(result_valid), 32'd0);
    div_start = 1'b0;
    repeat (2) next_cyc();
    rst = 1'b0;
    next_cyc();
    run_div("div min/-1", 1'b1, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
            33, 33);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
